// File: rtl/rr_pkt_arb_if.sv
// rr_pkt_arb_if: request/last/ack handshake and registered grant outputs of the arbiter.
interface rr_pkt_arb_if #(
  parameter int N = 4,
  parameter int W_ENC = (N > 1) ? $clog2(N) : 1
);
  logic [N-1:0] i_req;
  logic [N-1:0] i_last;
  logic i_ack;
  logic o_vld;
  logic [N-1:0] o_gnt;
  logic [W_ENC-1:0] o_gnt_enc;
  modport master (output i_req, i_last, i_ack, input o_vld, o_gnt, o_gnt_enc);
  modport slave (input i_req, i_last, i_ack, output o_vld, o_gnt, o_gnt_enc);
endinterface

// File: rtl/rr_pkt_arb.sv
// rr_pkt_arb: round-robin packet-locking arbiter; grant held until the grantee's last beat is accepted.
module pri #(
  parameter int N = 4,
  parameter bit FROM_LSB = 1
) (
  input  logic [N-1:0] req_i,
  output logic [N-1:0] gnt_o
);
  logic [N-1:0] r, g;
  for (genvar i = 0; i < N; i++) begin : g_rev
    assign r[i] = FROM_LSB ? req_i[i] : req_i[N-1-i];
    assign gnt_o[i] = FROM_LSB ? g[i] : g[N-1-i];
  end
  assign g = r & (~r + N'(1));
endmodule

module rr_pkt_arb #(
  parameter int N = 4,
  localparam int W_ENC = (N > 1) ? $clog2(N) : 1
) (
  input logic clk,
  input logic rst,
  rr_pkt_arb_if.slave bus
);
  typedef enum logic {IDLE, BUSY} state_e;
  state_e state_q, state_d;
  logic [N-1:0] mask_q, mask_d, gnt_q, gnt_d, mask_rel, sel_mask, req_m, pm, pr, pick;
  logic [W_ENC-1:0] enc_q, enc_d, pick_enc;
  logic rel;
  assign rel = state_q == BUSY && bus.i_ack && |(bus.i_last & gnt_q);
  // after a release only indices strictly above the old grantee keep priority
  assign mask_rel = ~(gnt_q | (gnt_q - N'(1)));
  assign sel_mask = state_q == IDLE ? mask_q : mask_rel;
  assign req_m = bus.i_req & sel_mask;
  pri #(.N(N), .FROM_LSB(1)) u_pri_m (.req_i(req_m), .gnt_o(pm));
  pri #(.N(N), .FROM_LSB(1)) u_pri_r (.req_i(bus.i_req), .gnt_o(pr));
  assign pick = |pm ? pm : pr;
  always_comb begin
    pick_enc = '0;
    for (int k = 0; k < N; k++) pick_enc = pick[k] ? (pick_enc | W_ENC'(k)) : pick_enc;
  end
  always_comb begin
    state_d = state_q;
    mask_d = mask_q;
    gnt_d = gnt_q;
    enc_d = enc_q;
    case (state_q)
      IDLE: if (|bus.i_req) begin
        state_d = BUSY;
        gnt_d = pick;
        enc_d = pick_enc;
      end
      BUSY: if (rel) begin
        mask_d = mask_rel;
        state_d = |bus.i_req ? BUSY : IDLE;
        gnt_d = pick;
        enc_d = pick_enc;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mask_q <= '1;
      gnt_q <= '0;
      enc_q <= '0;
    end else begin
      state_q <= state_d;
      mask_q <= mask_d;
      gnt_q <= gnt_d;
      enc_q <= enc_d;
    end
  end
  assign bus.o_vld = state_q == BUSY;
  assign bus.o_gnt = gnt_q;
  assign bus.o_gnt_enc = enc_q;
  a_hold: assert property (@(posedge clk) disable iff (rst)
    (state_q == BUSY && !(|(bus.i_req & gnt_q))) |-> rel)
    else $error("grantee dropped request before its last beat");
  a_onehot: assert property (@(posedge clk) disable iff (rst)
    (state_q == BUSY) |-> $onehot(gnt_q))
    else $error("grant not one-hot while valid");
endmodule

// File: tb/tb_rr_pkt_arb.sv
// tb_rr_pkt_arb: directed stimulus, cycle-level rotating-pointer model plus literal expectations.
module tb_rr_pkt_arb;
  localparam int N = 4;
  logic clk = 0;
  logic rst = 1;
  int checks = 0;
  int errors = 0;
  bit m_busy = 0;
  int m_g = 0;
  int m_ptr = 0;
  rr_pkt_arb_if #(.N(N)) bus ();
  rr_pkt_arb #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic int mpick(input logic [N-1:0] req, input int ptr);
    for (int k = 0; k < N; k++)
      if (req[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction
  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_busy = 0;
      m_g = 0;
      m_ptr = 0;
    end else if (!m_busy) begin
      if (|bus.i_req) begin
        m_g = mpick(bus.i_req, m_ptr);
        m_busy = 1;
      end
    end else if (bus.i_ack && bus.i_last[m_g]) begin
      m_ptr = (m_g + 1) % N;
      if (|bus.i_req) m_g = mpick(bus.i_req, m_ptr);
      else m_busy = 0;
    end
  end
  initial forever begin
    logic [N-1:0] eg;
    logic [1:0] ee;
    @(posedge clk);
    #1;
    eg = m_busy ? N'(1) << m_g : '0;
    ee = m_busy ? 2'(m_g) : 2'd0;
    checks += 3;
    if (bus.o_vld !== m_busy) begin
      errors++;
      $display("FAIL model_vld t=%0t got %b want %b", $time, bus.o_vld, m_busy);
    end
    if (bus.o_gnt !== eg) begin
      errors++;
      $display("FAIL model_gnt t=%0t got %b want %b", $time, bus.o_gnt, eg);
    end
    if (bus.o_gnt_enc !== ee) begin
      errors++;
      $display("FAIL model_enc t=%0t got %0d want %0d", $time, bus.o_gnt_enc, ee);
    end
  end
  task automatic step(input logic r, input logic [N-1:0] req, input logic [N-1:0] last, input logic ack);
    rst = r;
    bus.i_req = req;
    bus.i_last = last;
    bus.i_ack = ack;
    @(negedge clk);
  endtask
  task automatic chk(input string nm, input logic v, input logic [N-1:0] g, input logic [1:0] e);
    checks++;
    if (bus.o_vld !== v || bus.o_gnt !== g || bus.o_gnt_enc !== e) begin
      errors++;
      $display("FAIL %s got vld=%b gnt=%b enc=%0d want vld=%b gnt=%b enc=%0d",
               nm, bus.o_vld, bus.o_gnt, bus.o_gnt_enc, v, g, e);
    end
  endtask
  initial begin
    bus.i_req = '0;
    bus.i_last = '0;
    bus.i_ack = 0;
    @(negedge clk);
    step(1, 4'b0000, 4'b0000, 0);
    chk("reset", 0, 4'b0000, 2'd0);
    step(0, 4'b0000, 4'b1111, 1);
    chk("ack_idle_ignored", 0, 4'b0000, 2'd0);
    step(0, 4'b1010, 4'b0000, 0);
    chk("first_grant", 1, 4'b0010, 2'd1);
    step(0, 4'b1010, 4'b0010, 1);
    chk("b2b_to_3", 1, 4'b1000, 2'd3);
    step(0, 4'b1010, 4'b1000, 1);
    chk("wrap_to_1", 1, 4'b0010, 2'd1);
    step(0, 4'b0000, 4'b0010, 1);
    chk("release_idle", 0, 4'b0000, 2'd0);
    step(0, 4'b0011, 4'b0000, 0);
    chk("grant0", 1, 4'b0001, 2'd0);
    step(0, 4'b0011, 4'b0000, 1);
    chk("beat1_hold", 1, 4'b0001, 2'd0);
    step(0, 4'b0011, 4'b0011, 0);
    chk("gap_hold", 1, 4'b0001, 2'd0);
    step(0, 4'b0011, 4'b0010, 1);
    chk("beat2_hold", 1, 4'b0001, 2'd0);
    step(0, 4'b0011, 4'b0000, 0);
    step(0, 4'b0011, 4'b0001, 1);
    chk("beat3_next", 1, 4'b0010, 2'd1);
    step(0, 4'b0000, 4'b0010, 1);
    chk("idle_again", 0, 4'b0000, 2'd0);
    step(0, 4'b0001, 4'b0000, 0);
    chk("grant0_b", 1, 4'b0001, 2'd0);
    step(0, 4'b0001, 4'b0001, 1);
    chk("fallback_regrant0", 1, 4'b0001, 2'd0);
    step(0, 4'b0000, 4'b0001, 1);
    chk("idle_c", 0, 4'b0000, 2'd0);
    step(0, 4'b0100, 4'b0000, 0);
    chk("grant2", 1, 4'b0100, 2'd2);
    step(0, 4'b0100, 4'b0000, 1);
    step(1, 4'b0100, 4'b0000, 0);
    chk("reset_mid_pkt", 0, 4'b0000, 2'd0);
    step(0, 4'b1100, 4'b0000, 0);
    chk("mask_restored", 1, 4'b0100, 2'd2);
    step(0, 4'b0000, 4'b0100, 1);
    chk("idle_d", 0, 4'b0000, 2'd0);
    step(1, 4'b0000, 4'b0000, 0);
    for (int i = 0; i < 8; i++) begin
      step(0, 4'b1111, 4'b1111, 1);
      chk("soak", 1, 4'b0001 << (i % 4), 2'(i % 4));
    end
    step(0, 4'b0000, 4'b1111, 1);
    chk("soak_end", 0, 4'b0000, 2'd0);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
